// File: rtl/bram_wide_read_streamer_if.sv
// Purpose : bundles the control, RAM read-port and output-stream signals of
//           bram_wide_read_streamer into one interface.
// Signals : start/base_addr/length  -> transfer request
//           busy/done               <- transfer status
//           rce/ra                  <- RAM read enable / wide word address
//           rq                      -> RAM read data (1-cycle latency)
//           m_valid/m_data/m_ready  <> output valid/ready stream
// Modports: slave  = streamer view, master = environment (RAM + consumer) view
interface bram_wide_read_streamer_if #(
    parameter int RD_WIDTH  = 32,
    parameter int RA_WIDTH  = 10,
    parameter int LEN_WIDTH = 11
);
    logic                 start;
    logic [RA_WIDTH-1:0]  base_addr;
    logic [LEN_WIDTH-1:0] length;
    logic                 busy;
    logic                 done;
    logic                 rce;
    logic [RA_WIDTH-1:0]  ra;
    logic [RD_WIDTH-1:0]  rq;
    logic                 m_valid;
    logic [RD_WIDTH-1:0]  m_data;
    logic                 m_ready;

    modport slave (
        input  start, base_addr, length, rq, m_ready,
        output busy, done, rce, ra, m_valid, m_data
    );

    modport master (
        output start, base_addr, length, rq, m_ready,
        input  busy, done, rce, ra, m_valid, m_data
    );
endinterface

// File: rtl/bram_wide_read_streamer.sv
// Purpose : read-side sequencer for a narrow-write / wide-read BRAM. On start
//           it issues a run of wide-word reads, absorbs the RAM's 1-cycle read
//           latency in a 3-entry FIFO and streams the words out at up to one
//           word per cycle.
// Ports   : clk   - rising-edge clock shared with the RAM
//           rst_n - asynchronous active-low reset
//           bus   - bram_wide_read_streamer_if.slave (request, status, RAM read
//                   port, output stream)
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; start sampled here only
// S_RUN  | issuing reads and draining the FIFO
// S_DONE | one-cycle completion pulse, then back to S_IDLE
module bram_wide_read_streamer #(
    parameter int RD_WIDTH  = 32,
    parameter int RA_WIDTH  = 10,
    parameter int LEN_WIDTH = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    bram_wide_read_streamer_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [RA_WIDTH-1:0]  r_base;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_issued;
    logic [LEN_WIDTH-1:0] r_popped;
    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [RD_WIDTH-1:0]  r_mem [3];

    logic                 w_start_acc;
    logic                 w_rce;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_pop;

    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    // Credit check counts the word still in the RAM pipe, so the FIFO can never
    // overflow and rce never depends on m_ready.
    assign w_rce       = (r_state == S_RUN) && (r_issued < r_len) &&
                         (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
    assign w_push      = r_inflight;
    assign w_pop       = (r_occ != 2'd0) && bus.m_ready;
    assign w_last_pop  = w_pop && (r_popped == (r_len - LEN_WIDTH'(1)));

    assign bus.rce     = w_rce;
    assign bus.ra      = r_base + r_issued[RA_WIDTH-1:0];
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.m_valid = (r_occ != 2'd0);
    assign bus.m_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.length != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_inflight <= w_rce;
            if (w_start_acc) begin
                r_base   <= bus.base_addr;
                r_len    <= bus.length;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_rce) begin
                    r_issued <= r_issued + LEN_WIDTH'(1);
                end
                if (w_pop) begin
                    r_popped <= r_popped + LEN_WIDTH'(1);
                end
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.rq;
                r_wr_ptr        <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule
